// File: rtl/result_check_pkg.sv
// ============================================================================
// Module  : result_check_pkg
// Brief   : Shared types and constants for the result_check checker stage.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package result_check_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LATCH_C = 3'd1,
        ST_WAIT_R  = 3'd2,
        ST_LATCH_R = 3'd3,
        ST_WR_HI   = 3'd4,
        ST_WR_LO   = 3'd5,
        ST_WR_END  = 3'd6
    } state_t;

    localparam logic [4:0]  CMD_SET_BASE    = 5'h01;
    localparam logic [15:0] END_MARKER_WORD = 16'hFFFF;

    // Check FIFO entry layout; bits [50:48] are reserved
    localparam int CF_END_BIT  = 51;
    localparam int CF_EXP_MSB  = 47;
    localparam int CF_EXP_LSB  = 24;
    localparam int CF_MASK_MSB = 23;
    localparam int CF_MASK_LSB = 0;

    function automatic logic masked_match(input logic [23:0] resp,
                                          input logic [23:0] expected,
                                          input logic [23:0] mask);
        return (((resp ^ expected) & mask) == 24'd0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/result_check_wr.sv
// ============================================================================
// Module  : result_check_wr
// Brief   : Write-port holder: result pointer, write request and accept detect.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module result_check_wr #(
    parameter int                ADDR_W      = 20,
    parameter logic [ADDR_W-1:0] RESULT_BASE = 20'h80000
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              i_wr_req,
    input  logic [15:0]       i_wr_data,
    input  logic              i_load_en,
    input  logic [ADDR_W-1:0] i_load_addr,
    input  logic              i_waitrequest,
    output logic [ADDR_W-1:0] o_address,
    output logic [1:0]        o_byteenable,
    output logic              o_write,
    output logic [15:0]       o_writedata,
    output logic              o_accept
);

    logic [ADDR_W-1:0] r_ptr;

    // Pointer wraps naturally at the top of the address space
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_ptr <= RESULT_BASE;
        end else if (i_load_en) begin
            r_ptr <= i_load_addr;
        end else if (o_accept) begin
            r_ptr <= r_ptr + ADDR_W'(1);
        end
    end

    // Request and data come from registered state, so they hold during waitrequest
    assign o_write      = i_wr_req;
    assign o_accept     = i_wr_req & ~i_waitrequest;
    assign o_address    = i_wr_req ? r_ptr : '0;
    assign o_byteenable = i_wr_req ? 2'b11 : 2'b00;
    assign o_writedata  = i_wr_req ? i_wr_data : 16'h0000;

endmodule

`default_nettype wire

// File: rtl/result_check.sv
// ============================================================================
// Module  : result_check
// Brief   : Masked compare of captured responses, result records to SRAM.
//           Optional fail counter enabled by CHECK_STATS_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module result_check
    import result_check_pkg::*;
#(
    parameter int                ADDR_W      = 20,
    parameter logic [ADDR_W-1:0] RESULT_BASE = 20'h80000
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic [ADDR_W-1:0] mem_address,
    output logic [1:0]        mem_byteenable,
    output logic              mem_write,
    output logic [15:0]       mem_writedata,
    input  logic              mem_waitrequest,
    input  logic [23:0]       rfifo_data,
    output logic              rfifo_rdreq,
    input  logic              rfifo_rdempty,
    input  logic [51:0]       cfifo_data,
    output logic              cfifo_rdreq,
    input  logic              cfifo_rdempty,
    input  logic [4:0]        sc_cmd,
    input  logic [23:0]       sc_data,
    input  logic              sc_switching,
    output logic              sc_ready
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [23:0] r_expected;
    logic [23:0] r_mask;
    logic [23:0] r_resp;
    logic        r_pass;
    logic        w_pass;
    logic        w_wr_req;
    logic [15:0] w_wr_data;
    logic [15:0] w_end_word;
    logic        w_accept;
    logic        w_load_en;
    logic        w_unused;

    assign w_unused  = ^{cfifo_data[50:48], sc_data};
    assign w_pass    = masked_match(rfifo_data, r_expected, r_mask);
    assign sc_ready  = (r_state == ST_IDLE) && cfifo_rdempty;
    assign w_load_en = sc_switching && (sc_cmd == CMD_SET_BASE) && sc_ready;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_expected <= '0;
            r_mask     <= '0;
            r_resp     <= '0;
            r_pass     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_LATCH_C) begin
                r_expected <= cfifo_data[CF_EXP_MSB:CF_EXP_LSB];
                r_mask     <= cfifo_data[CF_MASK_MSB:CF_MASK_LSB];
            end
            if (r_state == ST_LATCH_R) begin
                r_resp <= rfifo_data;
                r_pass <= w_pass;
            end
        end
    end

    // sc_switching is only honoured in IDLE, so an in-flight record always completes
    always_comb begin
        w_state_nxt = r_state;
        cfifo_rdreq = 1'b0;
        rfifo_rdreq = 1'b0;
        w_wr_req    = 1'b0;
        w_wr_data   = 16'h0000;
        case (r_state)
            ST_IDLE: begin
                if (!sc_switching && !cfifo_rdempty) begin
                    cfifo_rdreq = 1'b1;
                    w_state_nxt = ST_LATCH_C;
                end
            end
            ST_LATCH_C: begin
                w_state_nxt = cfifo_data[CF_END_BIT] ? ST_WR_END : ST_WAIT_R;
            end
            ST_WAIT_R: begin
                if (!rfifo_rdempty) begin
                    rfifo_rdreq = 1'b1;
                    w_state_nxt = ST_LATCH_R;
                end
            end
            ST_LATCH_R: begin
                w_state_nxt = ST_WR_HI;
            end
            ST_WR_HI: begin
                w_wr_req  = 1'b1;
                w_wr_data = {r_pass, 7'b0, r_resp[23:16]};
                if (w_accept) w_state_nxt = ST_WR_LO;
            end
            ST_WR_LO: begin
                w_wr_req  = 1'b1;
                w_wr_data = r_resp[15:0];
                if (w_accept) w_state_nxt = ST_IDLE;
            end
            ST_WR_END: begin
                w_wr_req  = 1'b1;
                w_wr_data = w_end_word;
                if (w_accept) w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

`ifdef CHECK_STATS_EN
    logic [15:0] r_fail_cnt;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_fail_cnt <= '0;
        end else if (r_state == ST_LATCH_R && !w_pass && r_fail_cnt != 16'hFFFF) begin
            r_fail_cnt <= r_fail_cnt + 16'd1;
        end else if (r_state == ST_WR_END && w_accept) begin
            r_fail_cnt <= '0;
        end
    end

    assign w_end_word = r_fail_cnt;
`else
    assign w_end_word = END_MARKER_WORD;
`endif

    result_check_wr #(
        .ADDR_W      (ADDR_W),
        .RESULT_BASE (RESULT_BASE)
    ) u_wr (
        .clock         (clock),
        .reset_n       (reset_n),
        .i_wr_req      (w_wr_req),
        .i_wr_data     (w_wr_data),
        .i_load_en     (w_load_en),
        .i_load_addr   (sc_data[ADDR_W-1:0]),
        .i_waitrequest (mem_waitrequest),
        .o_address     (mem_address),
        .o_byteenable  (mem_byteenable),
        .o_write       (mem_write),
        .o_writedata   (mem_writedata),
        .o_accept      (w_accept)
    );

endmodule

`default_nettype wire

// File: tb/tb_result_check.sv
// ============================================================================
// Module  : tb_result_check
// Brief   : Directed vector bench for result_check with FIFO and SRAM models.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_result_check;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [19:0] mem_address;
    logic [1:0]  mem_byteenable;
    logic        mem_write;
    logic [15:0] mem_writedata;
    logic        mem_waitrequest = 1'b0;
    logic [23:0] rfifo_data = '0;
    logic        rfifo_rdreq;
    logic        rfifo_rdempty;
    logic [51:0] cfifo_data = '0;
    logic        cfifo_rdreq;
    logic        cfifo_rdempty;
    logic [4:0]  sc_cmd = '0;
    logic [23:0] sc_data = '0;
    logic        sc_switching = 1'b0;
    logic        sc_ready;

    result_check dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .mem_address     (mem_address),
        .mem_byteenable  (mem_byteenable),
        .mem_write       (mem_write),
        .mem_writedata   (mem_writedata),
        .mem_waitrequest (mem_waitrequest),
        .rfifo_data      (rfifo_data),
        .rfifo_rdreq     (rfifo_rdreq),
        .rfifo_rdempty   (rfifo_rdempty),
        .cfifo_data      (cfifo_data),
        .cfifo_rdreq     (cfifo_rdreq),
        .cfifo_rdempty   (cfifo_rdempty),
        .sc_cmd          (sc_cmd),
        .sc_data         (sc_data),
        .sc_switching    (sc_switching),
        .sc_ready        (sc_ready)
    );

    always #5 clock = ~clock;

    // Non-showahead FIFO models and SRAM write log
    logic [51:0] cq [0:63];
    logic [23:0] rq [0:63];
    int          c_wr = 0, c_rd = 0, r_wr = 0, r_rd = 0;
    logic [19:0] log_addr [0:63];
    logic [15:0] log_data [0:63];
    int          wr_cnt = 0;
    int          n_vec = 0, n_bad = 0;

    assign cfifo_rdempty = (c_rd == c_wr);
    assign rfifo_rdempty = (r_rd == r_wr);

    always @(posedge clock) begin
        if (cfifo_rdreq) begin
            if (cfifo_rdempty) begin
                n_bad++;
                $display("FAIL cfifo_pop_empty: rdreq=1 required 0 while empty");
            end else begin
                cfifo_data <= cq[c_rd];
                c_rd       <= c_rd + 1;
            end
        end
        if (rfifo_rdreq) begin
            if (rfifo_rdempty) begin
                n_bad++;
                $display("FAIL rfifo_pop_empty: rdreq=1 required 0 while empty");
            end else begin
                rfifo_data <= rq[r_rd];
                r_rd       <= r_rd + 1;
            end
        end
        if (mem_write && !mem_waitrequest && wr_cnt < 64) begin
            log_addr[wr_cnt] <= mem_address;
            log_data[wr_cnt] <= mem_writedata;
            wr_cnt           <= wr_cnt + 1;
        end
    end

    typedef struct {
        logic [23:0] expected;
        logic [23:0] mask;
        logic [23:0] resp;
        logic [15:0] w0;
        logic [15:0] w1;
    } vec_t;

    vec_t vecs [0:5];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic push_c(input logic e, input logic [23:0] expv, input logic [23:0] maskv);
        cq[c_wr] = {e, 3'b000, expv, maskv};
        c_wr++;
    endtask

    task automatic push_r(input logic [23:0] resp);
        rq[r_wr] = resp;
        r_wr++;
    endtask

    task automatic wait_wr(input int target, input string name);
        for (int i = 0; i < 200 && wr_cnt < target; i++) tick();
        check(name, 32'(wr_cnt >= target), 32'd1);
    endtask

    task automatic wait_write_req(input string name);
        for (int i = 0; i < 200 && !mem_write; i++) tick();
        check(name, 32'(mem_write), 32'd1);
    endtask

    logic [19:0] exp_ptr;
    logic [19:0] a_hold;
    logic [15:0] d_hold;
    logic        ok;
    int          base, rd_hold;
    logic [15:0] end_exp1, end_exp2;

    initial begin
`ifdef CHECK_STATS_EN
        end_exp1 = 16'h0002;
        end_exp2 = 16'h0001;
`else
        end_exp1 = 16'hFFFF;
        end_exp2 = 16'hFFFF;
`endif
        vecs[0] = '{24'h123456, 24'hFFFFFF, 24'h123456, 16'h8012, 16'h3456};
        vecs[1] = '{24'h0000FF, 24'h0000F0, 24'h0000F3, 16'h8000, 16'h00F3};
        vecs[2] = '{24'h0000FF, 24'h0000F0, 24'h0000EF, 16'h0000, 16'h00EF};
        vecs[3] = '{24'h000000, 24'h000000, 24'hABCDEF, 16'h80AB, 16'hCDEF};
        vecs[4] = '{24'h000000, 24'h800000, 24'hFFFFFF, 16'h00FF, 16'hFFFF};
        vecs[5] = '{24'hA5A5A5, 24'h00FF00, 24'h5AA55A, 16'h805A, 16'hA55A};

        tick(); tick(); tick();
        reset_n = 1'b1;
        tick();
        check("reset_mem_write", 32'(mem_write), 32'd0);
        check("reset_mem_address", 32'(mem_address), 32'd0);
        check("reset_sc_ready", 32'(sc_ready), 32'd1);
        check("reset_rdreq", {30'd0, cfifo_rdreq, rfifo_rdreq}, 32'd0);

        exp_ptr = 20'h80000;
        for (int i = 0; i < 6; i++) begin
            base = wr_cnt;
            push_c(1'b0, vecs[i].expected, vecs[i].mask);
            push_r(vecs[i].resp);
            wait_wr(base + 2, $sformatf("vec%0d_timeout", i));
            check($sformatf("vec%0d_addr0", i), 32'(log_addr[base]), 32'(exp_ptr));
            check($sformatf("vec%0d_word0", i), 32'(log_data[base]), 32'(vecs[i].w0));
            check($sformatf("vec%0d_addr1", i), 32'(log_addr[base + 1]), 32'(exp_ptr + 20'd1));
            check($sformatf("vec%0d_word1", i), 32'(log_data[base + 1]), 32'(vecs[i].w1));
            check($sformatf("vec%0d_ready", i), 32'(sc_ready), 32'd1);
            exp_ptr = exp_ptr + 20'd2;
        end

        // Waitrequest held for 5 cycles on the high word
        base = wr_cnt;
        mem_waitrequest = 1'b1;
        push_c(1'b0, 24'h000000, 24'h000000);
        push_r(24'h00C0DE);
        wait_write_req("wait_hi_timeout");
        a_hold = mem_address;
        d_hold = mem_writedata;
        check("wait_hi_addr", 32'(a_hold), 32'(exp_ptr));
        check("wait_hi_data", 32'(d_hold), 32'h8000);
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (!mem_write || mem_address !== a_hold || mem_writedata !== d_hold) ok = 1'b0;
        end
        check("wait_hi_stable", 32'(ok), 32'd1);
        check("wait_hi_no_write", 32'(wr_cnt), 32'(base));
        mem_waitrequest = 1'b0;
        wait_wr(base + 2, "wait_lo_timeout");
        tick(); tick(); tick();
        check("wait_write_count", 32'(wr_cnt - base), 32'd2);
        check("wait_lo_addr", 32'(log_addr[base + 1]), 32'(exp_ptr + 20'd1));
        exp_ptr = exp_ptr + 20'd2;

        // END marker after two failing vectors in the table
        base = wr_cnt;
        rd_hold = r_rd;
        push_c(1'b1, 24'h0, 24'h0);
        wait_wr(base + 1, "end1_timeout");
        tick(); tick(); tick();
        check("end1_addr", 32'(log_addr[base]), 32'(exp_ptr));
        check("end1_word", 32'(log_data[base]), 32'(end_exp1));
        check("end1_count", 32'(wr_cnt - base), 32'd1);
        check("end1_no_rpop", 32'(r_rd), 32'(rd_hold));
        exp_ptr = exp_ptr + 20'd1;

        // One failing vector then END
        base = wr_cnt;
        push_c(1'b0, 24'h000000, 24'hFFFFFF);
        push_r(24'h000001);
        push_c(1'b1, 24'h0, 24'h0);
        wait_wr(base + 3, "end2_timeout");
        check("end2_word0", 32'(log_data[base]), 32'h0000);
        check("end2_word", 32'(log_data[base + 2]), 32'(end_exp2));
        check("end2_addr", 32'(log_addr[base + 2]), 32'(exp_ptr + 20'd2));
        exp_ptr = exp_ptr + 20'd3;

        // Base load while idle, no pop while switching
        tick();
        sc_switching = 1'b1;
        sc_cmd = 5'h01;
        sc_data = 24'h000100;
        tick(); tick();
        rd_hold = c_rd;
        push_c(1'b0, 24'h0, 24'h0);
        for (int i = 0; i < 6; i++) tick();
        check("switch_no_cpop", 32'(c_rd), 32'(rd_hold));
        check("switch_ready_low", 32'(sc_ready), 32'd0);
        sc_switching = 1'b0;
        sc_cmd = 5'h00;
        base = wr_cnt;
        push_r(24'h000777);
        wait_wr(base + 2, "base_timeout");
        check("base_addr0", 32'(log_addr[base]), 32'h00100);
        check("base_addr1", 32'(log_addr[base + 1]), 32'h00101);
        exp_ptr = 20'h00102;

        // Response FIFO empty for 50 cycles
        base = wr_cnt;
        push_c(1'b0, 24'h0, 24'h0);
        ok = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (sc_ready !== 1'b0 || mem_write !== 1'b0) ok = 1'b0;
        end
        check("stall_quiet", 32'(ok), 32'd1);
        check("stall_no_write", 32'(wr_cnt), 32'(base));
        push_r(24'h5A5A5A);
        wait_wr(base + 2, "stall_timeout");
        check("stall_addr0", 32'(log_addr[base]), 32'(exp_ptr));
        check("stall_word1", 32'(log_data[base + 1]), 32'h5A5A);
        exp_ptr = exp_ptr + 20'd2;

        // Reset while the low word is pending
        mem_waitrequest = 1'b1;
        push_c(1'b0, 24'h0, 24'h0);
        push_r(24'h010203);
        wait_write_req("rst_hi_timeout");
        mem_waitrequest = 1'b0;
        tick();
        mem_waitrequest = 1'b1;
        check("rst_in_lo_write", 32'(mem_write), 32'd1);
        check("rst_in_lo_addr", 32'(mem_address), 32'(exp_ptr + 20'd1));
        reset_n = 1'b0;
        tick();
        check("rst_drop_write", 32'(mem_write), 32'd0);
        reset_n = 1'b1;
        mem_waitrequest = 1'b0;
        tick();
        check("rst_ready", 32'(sc_ready), 32'd1);
        base = wr_cnt;
        push_c(1'b0, 24'h0, 24'h0);
        push_r(24'h00ABCD);
        wait_wr(base + 2, "rst_rec_timeout");
        check("rst_ptr_base", 32'(log_addr[base]), 32'h80000);
        check("rst_rec_word1", 32'(log_data[base + 1]), 32'hABCD);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
